// File: rtl/e_cpu_io_xfer_ctrl.sv
// East-edge CPU I/O tile sequencer: streams two operands to the fabric as
// nibble beats, collects a byte-beat result and returns it to the CPU.
module e_cpu_io_xfer_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        UserCLK,
  input  logic        resetn,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_rs1,
  input  logic [31:0] cpu_rs2,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ready,
  output logic [31:0] cpu_rsp_data,
  output logic        cpu_rsp_err,
  output logic [3:0]  opa_o,
  output logic [3:0]  opb_o,
  output logic        op_valid_o,
  output logic        op_start_o,
  input  logic [3:0]  res0_i,
  input  logic [3:0]  res1_i,
  input  logic [3:0]  res2_i
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d, k_nx;
  logic [1:0]  j_q, j_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic [3:0]  opa_q, opa_d;
  logic [3:0]  opb_q, opb_d;
  logic        opv_q, opv_d;
  logic        ops_q, ops_d;
  logic        unused_ok;

  assign unused_ok = ^res2_i[3:2];
  assign k_nx = k_q + 3'd1;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    to_d    = to_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    opa_d   = 4'h0;
    opb_d   = 4'h0;
    opv_d   = 1'b0;
    ops_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) begin
          a_d     = cpu_rs1;
          b_d     = cpu_rs2;
          res_d   = 32'h0;
          err_d   = 1'b0;
          k_d     = 3'd0;
          state_d = SEND;
          // First beat is loaded here so it is on the lanes in SEND k=0
          opa_d   = cpu_rs1[3:0];
          opb_d   = cpu_rs2[3:0];
          opv_d   = 1'b1;
          ops_d   = 1'b1;
        end
      end
      SEND: begin
        if (k_q == 3'd7) begin
          state_d = WAIT;
          j_d     = 2'd0;
          to_d    = '0;
        end else begin
          k_d   = k_nx;
          opa_d = a_q[{k_nx, 2'b00} +: 4];
          opb_d = b_q[{k_nx, 2'b00} +: 4];
          opv_d = 1'b1;
        end
      end
      WAIT: begin
        if (res2_i[0]) begin
          res_d[{j_q, 3'b000} +: 8] = {res1_i, res0_i};
          err_d = err_q | res2_i[1];
          to_d  = '0;
          j_d   = j_q + 2'd1;
          if (j_q == 2'd3) state_d = RESP;
        end else if (to_q >= TO_W'(TIMEOUT - 1)) begin
          // This idle cycle is the TIMEOUT-th one in a row
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      RESP: begin
        if (cpu_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      j_q     <= 2'd0;
      to_q    <= '0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      res_q   <= 32'h0;
      err_q   <= 1'b0;
      opa_q   <= 4'h0;
      opb_q   <= 4'h0;
      opv_q   <= 1'b0;
      ops_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
      to_q    <= to_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opv_q   <= opv_d;
      ops_q   <= ops_d;
    end
  end

  assign cpu_req_ready = (state_q == IDLE);
  assign cpu_rsp_valid = (state_q == RESP);
  assign cpu_rsp_data  = (state_q == RESP) ? res_q : 32'h0;
  assign cpu_rsp_err   = (state_q == RESP) & err_q;
  assign opa_o         = opa_q;
  assign opb_o         = opb_q;
  assign op_valid_o    = opv_q;
  assign op_start_o    = ops_q;

endmodule

// File: tb/tb_e_cpu_io_xfer_ctrl.sv
// Directed bench for e_cpu_io_xfer_ctrl (TIMEOUT=16).
module tb_e_cpu_io_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  opa, opb;
  logic        opv, ops;
  logic [3:0]  res0 = 4'h0;
  logic [3:0]  res1 = 4'h0;
  logic [3:0]  res2 = 4'h0;

  int checks = 0;
  int errors = 0;

  e_cpu_io_xfer_ctrl #(.TIMEOUT(16), .TO_W(8)) dut (
    .UserCLK(clk),
    .resetn(rstn),
    .cpu_req_valid(req_valid),
    .cpu_req_ready(req_ready),
    .cpu_rs1(rs1),
    .cpu_rs2(rs2),
    .cpu_rsp_valid(rsp_valid),
    .cpu_rsp_ready(rsp_ready),
    .cpu_rsp_data(rsp_data),
    .cpu_rsp_err(rsp_err),
    .opa_o(opa),
    .opb_o(opb),
    .op_valid_o(opv),
    .op_start_o(ops),
    .res0_i(res0),
    .res1_i(res1),
    .res2_i(res2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    rs1 = a;
    rs2 = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic beats(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      res2 = 4'b0001;
      {res1, res0} = w[8*i +: 8];
      tick();
    end
    res2 = 4'b0000;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || opv !== 1'b0 ||
        ops !== 1'b0 || opa !== 4'h0 || opb !== 4'h0 ||
        rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rr=%b rv=%b ov=%b os=%b a=%h b=%h d=%h e=%b exp rr=1 rest 0",
               req_ready, rsp_valid, opv, ops, opa, opb, rsp_data, rsp_err);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] ea [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    logic [3:0] eb [8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    logic [7:0] rb [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    int cyc;
    issue(32'h87654321, 32'h0FEDCBA9);
    cyc = 1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (opa !== ea[k] || opb !== eb[k] || opv !== 1'b1 ||
          ops !== (k == 0) || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_send k=%0d got a=%h b=%h v=%b s=%b rr=%b exp a=%h b=%h v=1 s=%b rr=0",
                 k, opa, opb, opv, ops, req_ready, ea[k], eb[k], (k == 0));
      end
      tick();
      cyc++;
    end
    checks++;
    if (opv !== 1'b0 || ops !== 1'b0 || opa !== 4'h0) begin
      errors++;
      $display("FAIL basic_wait_lanes got v=%b s=%b a=%h exp 0", opv, ops, opa);
    end
    for (int i = 0; i < 4; i++) begin
      res2 = 4'b0001;
      {res1, res0} = rb[i];
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_valid cyc=%0d got %b exp 0", cyc, rsp_valid);
      end
      tick();
      cyc++;
    end
    res2 = 4'b0000;
    checks++;
    if (cyc !== 13 || rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 ||
        rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_rsp cyc=%0d got v=%b d=%h e=%b exp cyc=13 v=1 d=12345678 e=0",
               cyc, rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release got rv=%b rr=%b exp rv=0 rr=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_timeout();
    int n;
    issue(32'h11111111, 32'h22222222);
    repeat (8) tick();
    res2 = 4'b0001;
    {res1, res0} = 8'hAA;
    tick();
    res2 = 4'b0000;
    {res1, res0} = 8'h00;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_latency got %0d exp 16", n);
    end
    checks++;
    if (rsp_data !== 32'h000000AA || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rsp got d=%h e=%b exp d=000000aa e=1", rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    issue(32'hCAFEF00D, 32'h12345678);
    repeat (8) tick();
    beats(32'h44332211);
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h44332211 ||
          rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold i=%0d got v=%b d=%h e=%b rr=%b exp v=1 d=44332211 e=0 rr=0",
                 i, rsp_valid, rsp_data, rsp_err, req_ready);
      end
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_same_cycle got %b exp 0", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rr=%b rv=%b exp rr=1 rv=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_err_gaps();
    logic [7:0] rb [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [3:0] c2 [4] = '{4'b0001, 4'b0001, 4'b0011, 4'b1101};
    issue(32'h0, 32'h0);
    res2 = 4'b0001;
    {res1, res0} = 8'hFF;
    repeat (8) tick();
    res2 = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      repeat (5) tick();
      res2 = c2[b];
      {res1, res0} = rb[b];
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL gaps_early_valid beat=%0d got %b exp 0", b, rsp_valid);
      end
      tick();
      res2 = 4'b0000;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hEFBEADDE || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL gaps_rsp got v=%b d=%h e=%b exp v=1 d=efbeadde e=1",
               rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_midreset();
    int seen;
    issue(32'h87654321, 32'h0FEDCBA9);
    repeat (4) tick();
    checks++;
    if (opa !== 4'h5 || opb !== 4'hD || opv !== 1'b1) begin
      errors++;
      $display("FAIL mr_k4 got a=%h b=%h v=%b exp a=5 b=d v=1", opa, opb, opv);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (opv !== 1'b0 || opa !== 4'h0 || opb !== 4'h0 ||
        req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL mr_async got v=%b a=%h b=%h rr=%b rv=%b exp v=0 a=0 b=0 rr=1 rv=0",
               opv, opa, opb, req_ready, rsp_valid);
    end
    tick();
    rstn = 1'b1;
    seen = 0;
    res2 = 4'b0001;
    {res1, res0} = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) seen++;
      tick();
    end
    res2 = 4'b0000;
    checks++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mr_no_rsp got seen=%0d rr=%b exp seen=0 rr=1", seen, req_ready);
    end
    issue(32'hA5A5A5A5, 32'h5A5A5A5A);
    repeat (8) tick();
    beats(32'hCAFEBABE);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hCAFEBABE || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL mr_after got v=%b d=%h e=%b exp v=1 d=cafebabe e=0",
               rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    rs1 = 32'h00000003;
    rs2 = 32'h00000004;
    tick();
    rs1 = 32'h0000000B;
    rs2 = 32'h0000000C;
    repeat (8) tick();
    beats(32'h04030201);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h04030201 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rsp1 got v=%b d=%h rr=%b exp v=1 d=04030201 rr=0",
               rsp_valid, rsp_data, req_ready);
    end
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got rr=%b rv=%b exp rr=1 rv=0", req_ready, rsp_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (ops !== 1'b1 || opa !== 4'hB || opb !== 4'hC || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept2 got s=%b a=%h b=%h rr=%b exp s=1 a=b b=c rr=0",
               ops, opa, opb, req_ready);
    end
    repeat (8) tick();
    beats(32'hD3C2B1A0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hD3C2B1A0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rsp2 got v=%b d=%h e=%b exp v=1 d=d3c2b1a0 e=0",
               rsp_valid, rsp_data, rsp_err);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_backpressure();
    test_err_gaps();
    test_midreset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/e_cpu_io_xfer_ctrl.md
Name: e_cpu_io_xfer_ctrl

Overview:
Sequencer for the east-edge CPU I/O tile. It accepts one custom-instruction request at a time from the CPU, holding two 32-bit operands. It streams the operands into the fabric as eight 4-bit beats on the OPA/OPB lanes. It then collects a 32-bit result from the fabric as four beats on the RES0/RES1/RES2 lanes and returns it to the CPU with a valid/ready response. A timeout guards against fabric configurations that never answer.

Parameters:
TIMEOUT, 255, idle cycles allowed in WAIT between result beats before aborting; legal range ≥1.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
UserCLK  input  1  fabric user clock; all state updates on rising edge.
resetn  input  1  asynchronous active-low reset.
cpu_req_valid  input  1  CPU request valid.
cpu_req_ready  output  1  block can accept a request.
cpu_rs1  input  32  operand A.
cpu_rs2  input  32  operand B.
cpu_rsp_valid  output  1  response valid.
cpu_rsp_ready  input  1  CPU accepts the response.
cpu_rsp_data  output  32  result word.
cpu_rsp_err  output  1  fabric error or timeout.
opa_o  output  4  operand A nibble to fabric (OPA_O lane).
opb_o  output  4  operand B nibble to fabric (OPB_O lane).
op_valid_o  output  1  an operand beat is present.
op_start_o  output  1  first beat of a frame.
res0_i  input  4  result low nibble of the current byte (RES0_I lane).
res1_i  input  4  result high nibble of the current byte (RES1_I lane).
res2_i  input  4  control lane: [0] beat valid, [1] error, [3:2] ignored.

Behaviour:
- Reset (resetn=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except cpu_req_ready=1.
  - Internal registers, beat counters and timeout counter are cleared.
  - Reset asserted in any state, including mid-frame, abandons the transaction. No response is issued.
- States: IDLE, SEND, WAIT, RESP.
- IDLE:
  - cpu_req_ready=1; in every other state it is 0.
  - On cpu_req_valid&&cpu_req_ready: latch rs1 and rs2, clear the result register and err flag, set beat counter k=0, go to SEND.
- SEND (exactly 8 cycles, k=0..7):
  - opa_o=rs1[4k+3:4k] and opb_o=rs2[4k+3:4k], LSB nibble first.
  - op_valid_o=1; op_start_o=1 only when k=0.
  - res2_i is ignored in this state.
  - After k=7, go to WAIT with byte index j=0 and timeout counter=0.
- Operand outputs:
  - opa_o, opb_o, op_valid_o and op_start_o are registered.
  - They are 0 in every state other than SEND.
- WAIT:
  - Each cycle with res2_i[0]=1: store {res1_i,res0_i} into result[8j+7:8j], OR res2_i[1] into err, increment j, reset the timeout counter to 0.
  - Each cycle with res2_i[0]=0: increment the timeout counter.
  - After the beat with j=3 is captured, go to RESP.
  - If the timeout counter reaches TIMEOUT before all four beats arrive: go to RESP with err=1 and the partially captured data.
- RESP:
  - cpu_rsp_valid=1; cpu_rsp_data and cpu_rsp_err stay stable until the handshake.
  - On cpu_rsp_ready, go to IDLE. cpu_rsp_valid drops the next cycle and cpu_req_ready rises the same next cycle.
  - cpu_rsp_ready held high in advance completes in the first RESP cycle.
- Latency (zero wait on the fabric side):
  - Request accepted at cycle 0; SEND occupies cycles 1–8.
  - Result beats arrive in WAIT cycles 9–12; cpu_rsp_valid is asserted at cycle 13.
- Throughput and counters:
  - One transaction at a time; no request pipelining.
  - cpu_req_valid is ignored outside IDLE.
  - All counters saturate or are cleared per state; no wrap-around is visible.

Test Plan:
1. Basic transfer:
   - Stimulus: rs1=0x87654321, rs2=0x0FEDCBA9; fabric answers four back-to-back beats {res1,res0}=0x78,0x56,0x34,0x12.
   - Required: opa_o sequence 1,2,…,8; opb_o sequence 9,A,B,C,D,E,F,0; op_start_o only on the first beat; rsp_data=0x12345678, err=0; rsp_valid at cycle 13.
2. Timeout:
   - Stimulus: TIMEOUT=16, fabric sends one beat 0xAA and then is silent.
   - Required: rsp_valid 16 cycles after that beat, rsp_data=0x000000AA, err=1.
3. Backpressure:
   - Stimulus: hold cpu_rsp_ready=0 for 10 cycles during RESP.
   - Required: data/err stable throughout, req_ready stays 0; after ready is given, req_ready=1 one cycle later.
4. Error flag and gaps:
   - Stimulus: res2_i[1]=1 on beat 2 only; 5-cycle gaps between beats; res2_i=4'b0001 held during SEND.
   - Required: SEND-phase valids ignored, gaps do not time out, err=1, data correct.
5. Mid-frame reset:
   - Stimulus: assert resetn=0 at SEND beat k=4.
   - Required: outputs clear immediately (asynchronously); no rsp_valid; a new request after release completes normally.
6. Back-to-back requests:
   - Stimulus: cpu_req_valid held high across two transactions, with rsp_ready tied to 1.
   - Required: the second request is accepted in the cycle after the RESP handshake; both responses are correct.
